multicycle_controller: RTL and testbench

Sequencing FSM for the multicycle variant of the MIPS core. It replaces the single-cycle main decoder with a state machine that steps the shared datapath through fetch, decode, execute, memory and writeback phases. It also drives the register enables and mux selects for the shared ALU and the unified instruction/data memory. The ALU decoder is unchanged and consumes `alu_op` from this block.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/mc_output_decoder.sv | 84 ++++++++
 rtl/multicycle_controller.sv | 151 +++++++++++++++
 tb/tb_multicycle_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control path.
// Holds the opcode constants (also used by main_decoder), the 4-bit state
// encoding of the multicycle sequencer, the mux select / ALU op encodings
// and the control bundle passed from the output decoder to the top level.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_ADDIEX   = 4'd8,
        S_ADDIWB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Combinational control decoder for the multicycle sequencer.
// Ports:
//   state     in  current sequencer state
//   mem_ready in  memory completes the current request this cycle
//   ctrl      out register enables, mux selects and memory request bundle
// Only FETCH depends on mem_ready: the IR and PC load on the cycle the
// instruction word actually arrives.
module mc_output_decoder
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencer: steps the shared datapath through fetch,
// decode, execute, memory and writeback, and watches memory stalls.
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   opcode        instr[31:26] from the IR
//   mem_ready     memory completes the current request this cycle
//   mem_req .. alu_op  datapath controls, combinational from state + mem_ready
//   illegal_op    sticky, unsupported opcode seen in DECODE
//   mem_timeout   sticky, a memory wait ran past WAIT_MAX cycles
//   state_o       current state, debug only
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 on ready
// DECODE   | read registers, branch target into ALUOut
// MEMADR   | ALUOut <= A + sign-extended offset
// MEMREAD  | load data from ALUOut address
// MEMWB    | rt <= loaded data
// MEMWRITE | store B to ALUOut address
// EXECUTE  | R-type ALU operation
// ALUWB    | rd <= ALUOut
// ADDIEX   | A + sign-extended immediate
// ADDIWB   | rt <= ALUOut
// BRANCH   | compare A-B, conditional PC <= ALUOut
// JUMP     | PC <= jump target
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    // Keep at least one bit so WAIT_MAX = 0 still elaborates.
    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    state_t        state;
    state_t        state_nxt;
    ctrl_t         ctrl;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          bad_opcode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_EXECUTE:  state_nxt = S_ALUWB;
            S_ADDIEX:   state_nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
            default:    state_nxt = S_FETCH;
        endcase
    end

    assign waiting    = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign bad_opcode = (state == S_DECODE) && !is_supported(opcode);

    // The counter holds at WAIT_LIM; the next stalled cycle is the one that
    // exceeds the limit. The FSM keeps waiting regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (waiting && !mem_ready) begin
            if (wait_cnt == WAIT_LIM) begin
                mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else if (bad_opcode) begin
            illegal_op <= 1'b1;
        end
    end

    mc_output_decoder u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign branch     = ctrl.branch;
    assign pc_src     = ctrl.pc_src;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. The stimulus side walks each
// instruction through its phase list, drives mem_ready/opcode per cycle and
// queues the expected state, controls and flags; the monitor compares at
// every falling edge.
module tb_multicycle_controller;
    import mips_pkg::*;

    localparam int WM = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, mem_write, ir_write, pc_write, branch;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic       illegal_op, mem_timeout;
    logic [3:0] state_o;

    typedef struct packed {
        state_t      st;
        logic [15:0] outs;
        logic        ill;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic ill_m = 1'b0;
    logic tmo_m = 1'b0;

    multicycle_controller #(.WAIT_MAX(WM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .branch      (branch),
        .pc_src      (pc_src),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Output table straight from the state list; bit order
    // {mem_req,iord,mem_write,ir_write,pc_write,branch,pc_src,
    //  reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op}
    function automatic logic [15:0] exp_outs(input state_t s, input logic mr);
        logic       mq, io, mw, irw, pcw, br, rd, m2r, rw, sa;
        logic [1:0] pcs, sb, aop;
        mq = 0; io = 0; mw = 0; irw = 0; pcw = 0; br = 0;
        rd = 0; m2r = 0; rw = 0; sa = 0; pcs = 2'b00; sb = 2'b00; aop = 2'b00;
        case (s)
            S_FETCH:    begin mq = 1; sb = 2'b01; irw = mr; pcw = mr; end
            S_DECODE:   begin sb = 2'b11; end
            S_MEMADR:   begin sa = 1; sb = 2'b10; end
            S_MEMREAD:  begin mq = 1; io = 1; end
            S_MEMWB:    begin m2r = 1; rw = 1; end
            S_MEMWRITE: begin mq = 1; io = 1; mw = 1; end
            S_EXECUTE:  begin sa = 1; aop = 2'b10; end
            S_ALUWB:    begin rd = 1; rw = 1; end
            S_ADDIEX:   begin sa = 1; sb = 2'b10; end
            S_ADDIWB:   begin rw = 1; end
            S_BRANCH:   begin sa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
            S_JUMP:     begin pcw = 1; pcs = 2'b10; end
            default:    ;
        endcase
        return {mq, io, mw, irw, pcw, br, pcs, rd, m2r, rw, sa, sb, aop};
    endfunction

    function automatic logic op_ok(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b001000 || op == 6'b000100 || op == 6'b000010;
    endfunction

    task automatic step(input state_t s, input logic mr, input logic [5:0] op);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = mr;
        opcode    = op;
        exp_q.push_back('{st: s, outs: exp_outs(s, mr), ill: ill_m, tmo: tmo_m});
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_n     = 1'b0;
            mem_ready = 1'b0;
            ill_m     = 1'b0;
            tmo_m     = 1'b0;
            exp_q.push_back('{st: S_FETCH, outs: exp_outs(S_FETCH, 1'b0), ill: 1'b0, tmo: 1'b0});
        end
    endtask

    // A memory phase: w stalled cycles then one completing cycle. Any stall
    // beyond the WM-th one raises the timeout from the following cycle.
    task automatic mem_phase(input state_t s, input int w, input logic [5:0] op);
        for (int i = 1; i <= w; i++) begin
            step(s, 1'b0, op);
            if (i > WM) tmo_m = 1'b1;
        end
        step(s, 1'b1, op);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
        logic r;
        r = 1'($urandom_range(0, 1));
        mem_phase(S_FETCH, fw, op);
        step(S_DECODE, r, op);
        if (!op_ok(op)) begin
            ill_m = 1'b1;
            return;
        end
        case (op)
            6'b100011: begin
                step(S_MEMADR, r, op);
                if (abort) begin
                    step(S_MEMREAD, 1'b0, op);
                    do_reset(1);
                    return;
                end
                mem_phase(S_MEMREAD, mw, op);
                step(S_MEMWB, ~r, op);
            end
            6'b101011: begin
                step(S_MEMADR, r, op);
                mem_phase(S_MEMWRITE, mw, op);
            end
            6'b000000: begin step(S_EXECUTE, r, op); step(S_ALUWB, ~r, op); end
            6'b001000: begin step(S_ADDIEX, r, op);  step(S_ADDIWB, ~r, op); end
            6'b000100: step(S_BRANCH, r, op);
            default:   step(S_JUMP, r, op);
        endcase
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", {12'd0, state_o}, {12'd0, 4'(e.st)});
                chk("controls", {mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src,
                                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op},
                    e.outs);
                chk("illegal_op", {15'd0, illegal_op}, {15'd0, e.ill});
                chk("mem_timeout", {15'd0, mem_timeout}, {15'd0, e.tmo});
            end
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [5:0] op;
        int         fw, mw, sel;
        bit         ab;
        do_reset(2);
        // Directed sequence from the test plan.
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b100011, 0, 2, 0);
        run_instr(6'b101011, 0, 0, 0);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000010, 0, 0, 0);
        run_instr(6'b111111, 0, 0, 0);
        run_instr(6'b001000, 0, 0, 0);
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b000000, 3, 0, 0);
        run_instr(6'b101011, 0, 3, 0);
        run_instr(6'b000000, 5, 0, 0);
        run_instr(6'b100011, 0, 1, 0);
        run_instr(6'b100011, 0, 3, 1);
        run_instr(6'b101011, 1, 4, 0);
        do_reset(1);
        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b001000;
                4: op = 6'b000100;
                5: op = 6'b000010;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op_ok(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            ab = ($urandom_range(0, 9) == 0);
            run_instr(op, fw, mw, ab);
            if ($urandom_range(0, 39) == 0) do_reset(1);
        end
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
